event_packer: RTL and testbench

Downstream consumer of the sampler's captured events: completes the `event_ready`/`event_saved` handshake and latches the 16×64-bit event window. It then serialises the window as a framed 32-bit AXI-Stream packet with header, timestamp and trailer, ready for the DMA/UART FIFO. It holds at most one event; back-pressure is applied to the sampler by withholding `event_saved`.

---
 rtl/muon_daq_pkg.sv | 27 ++
 rtl/synchronizer.sv | 26 ++
 rtl/event_packer.sv | 119 +++++++++++
 tb/tb_event_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_daq_pkg.sv
// Shared types and constants for the muon DAQ event path (sampler -> packer).
package muon_daq_pkg;

  localparam int unsigned N_CH      = 16;
  localparam int unsigned N_SAMPLES = 64;
  localparam int unsigned PKT_WORDS = 35;

  localparam logic [15:0] HEADER_MAGIC_DEFAULT  = 16'hEB90;
  localparam logic [7:0]  TRAILER_MAGIC_DEFAULT = 8'hE0;

  typedef logic [N_CH-1:0][N_SAMPLES-1:0] event_t;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } packer_state_t;

  // One bit per channel: set when any sample of that channel is non-zero.
  function automatic logic [N_CH-1:0] channel_hits(input event_t ev);
    logic [N_CH-1:0] mask;
    for (int c = 0; c < N_CH; c++) begin
      mask[c] = |ev[c];
    end
    return mask;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for signals crossing in from another clock domain.
module synchronizer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/event_packer.sv
// Captures one sampler event window and streams it as a framed 35-word packet
// (header, timestamp, 32 data words, trailer) on a 32-bit AXI-Stream master.
module event_packer
  import muon_daq_pkg::*;
#(
  parameter logic [15:0] HEADER_MAGIC  = HEADER_MAGIC_DEFAULT,
  parameter logic [7:0]  TRAILER_MAGIC = TRAILER_MAGIC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           event_ready,
  input  logic [N_CH-1:0][N_SAMPLES-1:0] evento,
  output logic                           event_saved,
  output logic [31:0]                    m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic                           busy
);

  localparam logic [5:0] LastIdx = 6'(PKT_WORDS - 1);

  logic            ready_s;
  packer_state_t   state_q;
  logic [31:0]     ts_cnt_q;
  logic [15:0]     evt_cnt_q;
  logic            ack_pending_q;
  logic [5:0]      idx_q;
  event_t          buf_q;
  logic [31:0]     ts_lat_q;
  logic [15:0]     cnt_lat_q;
  logic [N_CH-1:0] hit_mask_q;
  logic            capture;
  logic [3:0]      ch;
  logic [31:0]     word;

  synchronizer #(
    .Width (1)
  ) u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .d     (event_ready),
    .q     (ready_s)
  );

  assign capture = (state_q == StIdle) && ready_s && !ack_pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ts_cnt_q      <= '0;
      evt_cnt_q     <= '0;
      ack_pending_q <= 1'b0;
      idx_q         <= '0;
      ts_lat_q      <= '0;
      cnt_lat_q     <= '0;
      hit_mask_q    <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      // Acknowledge stays up until the sampler has seen it and dropped its request.
      if (ack_pending_q && !ready_s) begin
        ack_pending_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            ts_lat_q      <= ts_cnt_q;
            cnt_lat_q     <= evt_cnt_q;
            hit_mask_q    <= channel_hits(evento);
            evt_cnt_q     <= evt_cnt_q + 16'd1;
            ack_pending_q <= 1'b1;
            idx_q         <= '0;
            state_q       <= StSend;
          end
        end
        StSend: begin
          if (m_tready) begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Wide window register has no reset: it is only observable while sending.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= evento;
    end
  end

  // Words 2..33 map to channel (idx/2 - 1); odd words carry the upper half.
  always_comb begin
    ch   = idx_q[4:1] - 4'd1;
    word = '0;
    if (idx_q == 6'd0) begin
      word = {HEADER_MAGIC, hit_mask_q};
    end else if (idx_q == 6'd1) begin
      word = ts_lat_q;
    end else if (idx_q == LastIdx) begin
      word = {TRAILER_MAGIC, 8'h00, cnt_lat_q};
    end else if (idx_q[0]) begin
      word = buf_q[ch][63:32];
    end else begin
      word = buf_q[ch][31:0];
    end
  end

  assign m_tvalid    = (state_q == StSend);
  assign busy        = m_tvalid;
  assign m_tdata     = m_tvalid ? word : '0;
  assign m_tlast     = m_tvalid && (idx_q == LastIdx);
  assign event_saved = ack_pending_q;

endmodule

// File: tb/tb_event_packer.sv
// Directed, table-driven bench for event_packer: packet contents, handshake timing,
// back-pressure stability, overlapping events and mid-packet reset.
module tb_event_packer;
  import muon_daq_pkg::*;

  logic        clk;
  logic        reset;
  logic        event_ready;
  event_t      evento;
  logic        event_saved;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;

  event_packer dut (
    .clk         (clk),
    .reset       (reset),
    .event_ready (event_ready),
    .evento      (evento),
    .event_saved (event_saved),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [15:0] mask;
    bit          toggle;
    logic [31:0] w0;
    int          cycles;
  } vec_t;

  vec_t        vecs[4];
  int          errors = 0;
  int          checks = 0;
  int          rst_edge;
  int          last_edge;
  int          pkt_n;
  int          pkt_cycles;
  int          saved_bad;
  logic [31:0] got[35];
  logic        gotl[35];
  event_t      cur_ev;
  event_t      pend_ev;
  logic [31:0] exp_ts;
  logic [15:0] exp_cnt;
  logic [31:0] ts_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic event_t plan_ev();
    event_t ev;
    for (int c = 0; c < 16; c++) begin
      ev[c] = {32'(32'hC0DE_0000 + c), 32'(32'h0000_1000 + c)};
    end
    return ev;
  endfunction

  // Odd channels non-zero only in the upper half, even channels only in the lower.
  function automatic event_t mask_ev(input logic [15:0] m);
    event_t ev;
    ev = '0;
    for (int c = 0; c < 16; c++) begin
      if (m[c]) begin
        if (c % 2 == 1) ev[c] = {32'(32'hA5A5_0000 + c), 32'h0};
        else            ev[c] = {32'h0, 32'(32'h5A5A_0000 + c)};
      end
    end
    return ev;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    int c;
    if (i == 34) return {8'hE0, 8'h00, exp_cnt};
    c = (i - 2) / 2;
    return (i % 2 == 0) ? cur_ev[c][31:0] : cur_ev[c][63:32];
  endfunction

  task automatic wait_saved(input logic level, output int edges);
    edges = 0;
    while (event_saved !== level && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("saved_wait", {31'b0, event_saved}, {31'b0, level});
  endtask

  // Capture with the sampler's handshake; sets the expected timestamp.
  task automatic raise_and_capture(input event_t ev, output int edges);
    evento      = ev;
    event_ready = 1'b1;
    wait_saved(1'b1, edges);
    exp_ts = 32'(edge_cnt - 1 - rst_edge);
  endtask

  task automatic collect(input bit toggle, input int raise_at, input int abort_at);
    int          n;
    int          k;
    bit          stalled;
    bit          raised;
    logic [31:0] pd;
    logic        pl;
    n = 0; k = 0; stalled = 0; raised = 0; saved_bad = 0; pd = '0; pl = 1'b0;
    for (int g = 0; g < 300 && n < 35; g++) begin
      if (m_tvalid) begin
        if (abort_at >= 0 && n == abort_at) break;
        if (raise_at >= 0 && n == raise_at && !raised) begin
          evento      = pend_ev;
          event_ready = 1'b1;
          raised      = 1'b1;
        end
        if (raised && event_saved) saved_bad++;
        m_tready = toggle ? (k % 2 == 0) : 1'b1;
        if (stalled) begin
          chk("stall_data", m_tdata, pd);
          chk("stall_last", {31'b0, m_tlast}, {31'b0, pl});
        end
        if (m_tready) begin
          got[n]  = m_tdata;
          gotl[n] = m_tlast;
          n++;
          stalled = 0;
          if (n == 35) last_edge = edge_cnt + 1;
        end else begin
          stalled = 1;
          pd      = m_tdata;
          pl      = m_tlast;
        end
        k++;
      end
      @(posedge clk); #1;
    end
    m_tready   = 1'b1;
    pkt_n      = n;
    pkt_cycles = k;
  endtask

  task automatic check_packet(input string tag, input logic [31:0] w0, input int cyc);
    int bad_last;
    bad_last = 0;
    chk({tag, "_words"}, pkt_n, 35);
    if (pkt_n == 35) begin
      chk({tag, "_w0"}, got[0], w0);
      chk({tag, "_ts"}, got[1], exp_ts);
      for (int i = 2; i < 35; i++) begin
        chk($sformatf("%s_w%0d", tag, i), got[i], exp_word(i));
      end
      for (int i = 0; i < 35; i++) begin
        if (gotl[i] !== (i == 34)) bad_last++;
      end
      chk({tag, "_tlast"}, bad_last, 0);
    end
    chk({tag, "_cycles"}, pkt_cycles, cyc);
    chk({tag, "_valid_drop"}, {31'b0, m_tvalid}, 32'd0);
  endtask

  initial begin
    int e;
    int nvalid;

    vecs[0] = '{mask: 16'h0020, toggle: 1'b0, w0: 32'hEB90_0020, cycles: 35};
    vecs[1] = '{mask: 16'h0000, toggle: 1'b0, w0: 32'hEB90_0000, cycles: 35};
    vecs[2] = '{mask: 16'h8001, toggle: 1'b1, w0: 32'hEB90_8001, cycles: 69};
    vecs[3] = '{mask: 16'hFFFF, toggle: 1'b1, w0: 32'hEB90_FFFF, cycles: 69};

    reset = 1'b1; event_ready = 1'b0; evento = '0; m_tready = 1'b1;
    exp_cnt = 16'd0; last_edge = 0; ts_a = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_saved", {31'b0, event_saved}, 32'd0);
    chk("rst_valid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_last", {31'b0, m_tlast}, 32'd0);
    chk("rst_data", m_tdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    rst_edge = edge_cnt;

    // First event; a second one is raised while the first is being sent.
    cur_ev = plan_ev();
    raise_and_capture(cur_ev, e);
    chk("p1_saved_latency", e, 3);
    chk("p1_valid_up", {31'b0, m_tvalid}, 32'd1);
    chk("p1_busy_up", {31'b0, busy}, 32'd1);
    event_ready = 1'b0;
    pend_ev = mask_ev(16'h0300);
    collect(1'b0, 10, -1);
    chk("p1_saved_held_off", saved_bad, 0);
    check_packet("p1", 32'hEB90_FFFF, 35);
    chk("p1_w2", got[2], 32'h0000_1000);
    chk("p1_w3", got[3], 32'hC0DE_0000);
    chk("p1_w33", got[33], 32'hC0DE_000F);
    chk("p1_w34", got[34], 32'hE000_0000);
    ts_a = got[1];

    cur_ev = pend_ev;
    raise_and_capture(cur_ev, e);
    chk("p2_gap", edge_cnt, last_edge + 1);
    event_ready = 1'b0;
    exp_cnt = 16'd1;
    collect(1'b0, -1, -1);
    check_packet("p2", 32'hEB90_0300, 35);
    chk("p2_w34", got[34], 32'hE000_0001);
    chk("p2_ts_later", {31'b0, got[1] > ts_a}, 32'd1);

    for (int v = 0; v < 4; v++) begin
      exp_cnt = exp_cnt + 16'd1;
      cur_ev = mask_ev(vecs[v].mask);
      raise_and_capture(cur_ev, e);
      chk($sformatf("v%0d_saved_latency", v), e, 3);
      event_ready = 1'b0;
      collect(vecs[v].toggle, -1, -1);
      check_packet($sformatf("v%0d", v), vecs[v].w0, vecs[v].cycles);
    end

    // Request held high after acknowledge: must not capture twice.
    exp_cnt = exp_cnt + 16'd1;
    cur_ev = mask_ev(16'h00F0);
    raise_and_capture(cur_ev, e);
    collect(1'b0, -1, -1);
    check_packet("held", 32'hEB90_00F0, 35);
    nvalid = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_tvalid) nvalid++;
    end
    chk("held_no_recapture", nvalid, 0);
    chk("held_saved_high", {31'b0, event_saved}, 32'd1);
    event_ready = 1'b0;
    wait_saved(1'b0, e);
    chk("drop_to_saved_low", {31'b0, (e >= 2 && e <= 3)}, 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    raise_and_capture(cur_ev, e);
    event_ready = 1'b0;
    collect(1'b0, -1, -1);
    check_packet("rearm", 32'hEB90_00F0, 35);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_tvalid) nvalid++;
    end
    chk("rearm_single_packet", nvalid, 0);

    // Reset while word 10 is on the bus.
    cur_ev = plan_ev();
    raise_and_capture(cur_ev, e);
    event_ready = 1'b0;
    collect(1'b0, -1, 10);
    chk("abort_at_word", pkt_n, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", {31'b0, m_tvalid}, 32'd0);
    chk("abort_last", {31'b0, m_tlast}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_saved", {31'b0, event_saved}, 32'd0);
    reset = 1'b0;
    rst_edge = edge_cnt;
    exp_cnt = 16'd0;
    raise_and_capture(cur_ev, e);
    chk("post_rst_latency", e, 3);
    event_ready = 1'b0;
    collect(1'b0, -1, -1);
    check_packet("post_rst", 32'hEB90_FFFF, 35);
    chk("post_rst_ts_small", {31'b0, got[1] < 32'd10}, 32'd1);
    chk("post_rst_w34", got[34], 32'hE000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
